fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
- Initiator-side controller that drives the fpu_core start/busy/result protocol on behalf of the CPU execute stage.
- Accepts tagged FP requests over valid/ready and issues a one-cycle start with the operation and operands.
- Tracks fpu_core busy and returns the result with its tag over valid/ready.
- Guards against core protocol faults with a busy-assert check and a watchdog timeout; on a fault, returns a flagged NaN response.

Parameters:
- WIDTH, 32: operand/result width; must match the fpu_core instance.
- TAG_W, 5: request tag width (rd index).
- TIMEOUT, 64: maximum busy cycles before a watchdog error; legal range 2..65535.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at posedge
- req_op  in  fpu_p::Operation  operation (ADD/SUB/MUL)
- req_a  in  WIDTH  operand a (IEEE-754 bits)
- req_b  in  WIDTH  operand b
- req_tag  in  TAG_W  tag echoed on the response
- fpu_start  out  1  one-cycle start pulse to fpu_core
- fpu_op  out  fpu_p::Operation  op to fpu_core
- fpu_a  out  WIDTH  operand a to fpu_core
- fpu_b  out  WIDTH  operand b to fpu_core
- fpu_busy  in  1  fpu_core busy
- fpu_result  in  WIDTH  fpu_core result, valid when busy falls
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  WIDTH  result bits
- rsp_tag  out  TAG_W  echoed tag
- rsp_err  out  2  00 ok, 01 busy never asserted, 10 timeout
- last_latency  out  16  busy cycles of the last completed operation

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, except req_ready=1 once rst is released.
  - fpu_op resets to ADD.
  - An in-flight operation is abandoned and no response is produced.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - req_ready=1.
  - On accept, register op, a, b and tag, then go to ISSUE.
  - req_ready=0 in every other state; at most one request is outstanding.
- ISSUE (exactly 1 cycle):
  - fpu_start=1, with fpu_op/fpu_a/fpu_b driven from the registers.
  - Operands are cleared to 0 the cycle after start; fpu_core latches them at start.
  - Next state: WAIT. The watchdog counter clears to 0.
- WAIT, first cycle:
  - fpu_busy must be 1.
  - If fpu_busy=0: rsp_err=01, rsp_result=32'h7FC00000 (canonical qNaN), go to RESP.
- WAIT, subsequent cycles:
  - The counter increments on every busy=1 cycle.
  - On busy=0: capture fpu_result, set last_latency=counter, rsp_err=00, go to RESP.
  - If the counter reaches TIMEOUT while busy=1: rsp_err=10, rsp_result=qNaN, go to RESP with the DRAIN flag set.
- Latency: request accepted at edge N, start at edge N+1, result captured at the first edge where busy is sampled low. rsp_valid rises the cycle after that capture.
- RESP:
  - rsp_valid=1, with rsp_result/tag/err held stable while rsp_ready=0 (no data change under backpressure).
  - On rsp_ready: go to IDLE, or to DRAIN if the flag is set.
- DRAIN:
  - Wait for fpu_busy=0 and discard fpu_result, then go to IDLE.
  - DRAIN is exited by reset only if the core never drops busy.
- Counter width is 16; saturates at 16'hFFFF.
- last_latency holds its value across errors; it updates only on ok completions.
- req_valid asserted in any non-IDLE state is ignored; the request is not consumed.

Decomposition:
- fpu_p package:
  - Existing Operation enum.
  - Add fpu_p::IssueState enum (IDLE, ISSUE, WAIT, RESP, DRAIN).
  - Add fpu_p::RspErr constants (ERR_NONE, ERR_NOBUSY, ERR_TIMEOUT).
  - Add localparam CANON_QNAN = 32'h7FC00000.
- One natural sub-module: fpu_issue_watchdog (clear/inc/saturating 16-bit counter with timeout compare).

Test Plan:
- ADD, 3.0 (40400000) + 2.0 (40000000), tag 7, rsp_ready=1, real fpu_core:
  - Exactly one fpu_start pulse.
  - rsp_result=40A00000, rsp_tag=7, rsp_err=00.
  - last_latency equals the observed busy cycles.
- SUB, -12.0 (C1400000) - 10.0 (41200000), rsp_ready held 0 for 10 cycles:
  - rsp_valid stays high with rsp_result=C1B00000 stable.
  - req_ready=0 until the handshake; a second req_valid during this time is not accepted.
- MUL, 10.0 × -12.0:
  - rsp_result=C2F00000.
  - Back-to-back request accepted in the cycle after the rsp handshake, with no lost or duplicated starts.
- Stub core that never raises busy:
  - rsp_err=01, rsp_result=7FC00000, one cycle after the start-following edge.
  - Returns to IDLE.
- Stub core holding busy=1 for 200 cycles, TIMEOUT=64:
  - rsp_err=10 after 64 busy cycles.
  - Controller stays in DRAIN (req_ready=0) until busy falls, then req_ready=1.
- Reset asserted in WAIT mid-operation:
  - All outputs 0 immediately (asynchronous).
  - No response after release; a fresh ADD request completes correctly.

Source files
------------

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared types for the FPU issue controller: operation codes, controller states,
// response error codes and the canonical quiet NaN returned on faults.
package fpu_p;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2
  } Operation;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } IssueState;

  typedef logic [1:0] RspErr;

  localparam RspErr ERR_NONE    = 2'b00;
  localparam RspErr ERR_NOBUSY  = 2'b01;
  localparam RspErr ERR_TIMEOUT = 2'b10;

  localparam logic [31:0] CANON_QNAN = 32'h7FC00000;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    if (val == 16'hFFFF) begin
      return 16'hFFFF;
    end else begin
      return val + 16'd1;
    end
  endfunction

endpackage

// File: rtl/fpu_issue_watchdog.sv
// Busy-cycle counter for the issue controller: clears at start, counts busy
// cycles with saturation, and flags the cycle on which TIMEOUT would be reached.
module fpu_issue_watchdog
  import fpu_p::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count,
  output logic        hit
);

  logic [15:0] count_r;

  // Saturating busy-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= 16'd0;
    end else if (clr) begin
      count_r <= 16'd0;
    end else if (inc) begin
      count_r <= sat_inc16(count_r);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  // True while the current busy sample would be the TIMEOUT-th one.
  assign hit   = (count_r >= 16'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Initiator-side controller for fpu_core: accepts one tagged request at a time,
// pulses start, waits on busy with a watchdog, and returns a tagged response.
module fpu_issue_ctrl
  import fpu_p::*;
#(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  fpu_p::Operation  req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             fpu_start,
  output fpu_p::Operation  fpu_op,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  input  logic             fpu_busy,
  input  logic [WIDTH-1:0] fpu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [1:0]       rsp_err,
  output logic [15:0]      last_latency
);

  IssueState        state_r;
  logic [TAG_W-1:0] tag_r;
  logic             drain_r;
  logic             first_r;
  logic             req_ready_r;
  logic             fpu_start_r;
  Operation         fpu_op_r;
  logic [WIDTH-1:0] fpu_a_r;
  logic [WIDTH-1:0] fpu_b_r;
  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_result_r;
  logic [TAG_W-1:0] rsp_tag_r;
  RspErr            rsp_err_r;
  logic [15:0]      last_latency_r;
  logic             wd_clr_s;
  logic             wd_inc_s;
  logic [15:0]      wd_count_s;
  logic             wd_hit_s;

  assign wd_clr_s = (state_r == ISSUE);
  assign wd_inc_s = (state_r == WAIT) && fpu_busy;

  fpu_issue_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (wd_clr_s),
    .inc   (wd_inc_s),
    .count (wd_count_s),
    .hit   (wd_hit_s)
  );

  // Issue/response state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      tag_r          <= {TAG_W{1'b0}};
      drain_r        <= 1'b0;
      first_r        <= 1'b0;
      req_ready_r    <= 1'b0;
      fpu_start_r    <= 1'b0;
      fpu_op_r       <= ADD;
      fpu_a_r        <= {WIDTH{1'b0}};
      fpu_b_r        <= {WIDTH{1'b0}};
      rsp_valid_r    <= 1'b0;
      rsp_result_r   <= {WIDTH{1'b0}};
      rsp_tag_r      <= {TAG_W{1'b0}};
      rsp_err_r      <= ERR_NONE;
      last_latency_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_r) begin
            req_ready_r <= 1'b0;
            fpu_start_r <= 1'b1;
            fpu_op_r    <= req_op;
            fpu_a_r     <= req_a;
            fpu_b_r     <= req_b;
            tag_r       <= req_tag;
            state_r     <= ISSUE;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ISSUE: begin
          // The core latches its operands at start, so they can be dropped now.
          fpu_start_r <= 1'b0;
          fpu_a_r     <= {WIDTH{1'b0}};
          fpu_b_r     <= {WIDTH{1'b0}};
          first_r     <= 1'b1;
          state_r     <= WAIT;
        end
        WAIT: begin
          first_r <= 1'b0;
          if (!fpu_busy) begin
            rsp_valid_r <= 1'b1;
            rsp_tag_r   <= tag_r;
            drain_r     <= 1'b0;
            state_r     <= RESP;
            if (first_r) begin
              rsp_err_r    <= ERR_NOBUSY;
              rsp_result_r <= WIDTH'(CANON_QNAN);
            end else begin
              rsp_err_r      <= ERR_NONE;
              rsp_result_r   <= fpu_result;
              last_latency_r <= wd_count_s;
            end
          end else if (wd_hit_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_tag_r    <= tag_r;
            rsp_err_r    <= ERR_TIMEOUT;
            rsp_result_r <= WIDTH'(CANON_QNAN);
            drain_r      <= 1'b1;
            state_r      <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            if (drain_r) begin
              state_r <= DRAIN;
            end else begin
              req_ready_r <= 1'b1;
              state_r     <= IDLE;
            end
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        DRAIN: begin
          // A timed-out core may still finish; its result is discarded.
          if (!fpu_busy) begin
            drain_r     <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b0;
          fpu_start_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          drain_r     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_r;
  assign fpu_start    = fpu_start_r;
  assign fpu_op       = fpu_op_r;
  assign fpu_a        = fpu_a_r;
  assign fpu_b        = fpu_b_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_result   = rsp_result_r;
  assign rsp_tag      = rsp_tag_r;
  assign rsp_err      = rsp_err_r;
  assign last_latency = last_latency_r;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized bench for fpu_issue_ctrl: a latency-programmable core stub plus a
// transaction-timeline reference model checked against the DUT every cycle.
module tb_fpu_issue_ctrl;
  import fpu_p::*;

  localparam int TO = 64;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  Operation    req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_tag;
  logic        fpu_start;
  Operation    fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_busy;
  logic [31:0] fpu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_tag;
  logic [1:0]  rsp_err;
  logic [15:0] last_latency;

  int tests = 0;
  int fails = 0;
  int cur_lat = 0;

  fpu_issue_ctrl #(.WIDTH(32), .TAG_W(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_busy(fpu_busy), .fpu_result(fpu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .last_latency(last_latency)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in arithmetic: exact IEEE answers for the directed vectors, a fixed mix otherwise.
  function automatic logic [31:0] core_fn(input Operation op, input logic [31:0] a, input logic [31:0] b);
    if (op == ADD && a == 32'h40400000 && b == 32'h40000000) return 32'h40A00000;
    if (op == SUB && a == 32'hC1400000 && b == 32'h41200000) return 32'hC1B00000;
    if (op == MUL && a == 32'h41200000 && b == 32'hC1400000) return 32'hC2F00000;
    return (a ^ {b[15:0], b[31:16]}) + 32'(op);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Core stub: busy for exactly cur_lat cycles after start (0 means busy never rises).
  logic        core_busy;
  int          core_cnt;
  Operation    c_op;
  logic [31:0] c_a, c_b, core_res;
  assign fpu_busy   = core_busy;
  assign fpu_result = core_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_busy <= 1'b0; core_cnt <= 0; core_res <= 32'd0;
      c_op <= ADD; c_a <= 32'd0; c_b <= 32'd0;
    end else if (fpu_start) begin
      core_busy <= (cur_lat != 0); core_cnt <= cur_lat;
      c_op <= fpu_op; c_a <= fpu_a; c_b <= fpu_b; core_res <= 32'hDEADBEEF;
    end else if (core_busy) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_busy <= 1'b0;
        core_res  <= core_fn(c_op, c_a, c_b);
      end
    end
  end

  // Reference model: each accepted request is turned into a timeline of edge numbers.
  int          cyc, acc, hs, rsp_at, t_lat, s_lat;
  bit          act, done_hs, m_ready, m_start, m_valid;
  bit          s_rst, s_rv, s_rr;
  logic [15:0] m_lat_out;
  Operation    t_op, s_op;
  logic [31:0] t_a, t_b, t_res, s_a, s_b;
  logic [4:0]  t_tag, s_tag;
  logic [1:0]  t_err;

  initial begin
    cyc = 0; act = 0; done_hs = 0; m_ready = 0; m_start = 0; m_valid = 0; m_lat_out = 16'd0;
    forever begin
      @(posedge clk);
      s_rst = rst; s_rv = req_valid; s_rr = rsp_ready; s_lat = cur_lat;
      s_op = req_op; s_a = req_a; s_b = req_b; s_tag = req_tag;
      #1;
      cyc++;
      if (!s_rst) begin
        act = 0; done_hs = 0; m_ready = 0; m_start = 0; m_valid = 0; m_lat_out = 16'd0;
      end else begin
        m_start = 0;
        if (!act) begin
          if (m_ready && s_rv) begin
            act = 1; done_hs = 0; acc = cyc; m_ready = 0; m_start = 1;
            t_op = s_op; t_a = s_a; t_b = s_b; t_tag = s_tag; t_lat = s_lat;
            if (s_lat == 0) begin
              t_err = 2'd1; t_res = 32'h7FC00000; rsp_at = cyc + 2;
            end else if (s_lat < TO) begin
              t_err = 2'd0; t_res = core_fn(s_op, s_a, s_b); rsp_at = cyc + 2 + s_lat;
            end else begin
              t_err = 2'd2; t_res = 32'h7FC00000; rsp_at = cyc + 1 + TO;
            end
          end else begin
            m_ready = 1;
          end
        end else begin
          if (m_valid && s_rr) begin
            m_valid = 0; done_hs = 1; hs = cyc;
            if (t_err != 2'd2) begin act = 0; m_ready = 1; end
          end else if (!done_hs && cyc == rsp_at) begin
            m_valid = 1;
            if (t_err == 2'd0) m_lat_out = 16'(t_lat);
          end
          if (done_hs && act && cyc >= hs + 1 && cyc >= acc + 2 + t_lat) begin
            act = 0; m_ready = 1;
          end
        end
      end
      chk("req_ready", req_ready, m_ready);
      chk("fpu_start", fpu_start, m_start);
      chk("rsp_valid", rsp_valid, m_valid);
      chk("last_latency", last_latency, m_lat_out);
      if (m_start) begin
        chk("fpu_op", fpu_op, t_op);
        chk("fpu_a", fpu_a, t_a);
        chk("fpu_b", fpu_b, t_b);
      end else begin
        chk("fpu_a_idle", fpu_a, 32'd0);
        chk("fpu_b_idle", fpu_b, 32'd0);
      end
      if (m_valid) begin
        chk("rsp_result", rsp_result, t_res);
        chk("rsp_tag", rsp_tag, t_tag);
        chk("rsp_err", rsp_err, t_err);
      end
    end
  end

  // One request/response transaction; bp = cycles of backpressure once valid.
  task automatic do_req(input Operation op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int lat, input int bp, input bit noise,
                        output logic [31:0] r_res, output logic [4:0] r_tag,
                        output logic [1:0] r_err, output int acc_wait);
    bit got;
    int cnt;
    r_res = 32'd0; r_tag = 5'd0; r_err = 2'd0; acc_wait = 0;
    cur_lat = lat;
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    got = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(posedge clk);
      acc_wait++;
      if (req_ready) got = 1;
    end
    #2;
    req_valid = 1'b0;
    if (!got) begin
      chk("accept_bound", 32'(got), 32'd1);
      return;
    end
    got = 0; cnt = 0; rsp_ready = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(posedge clk);
      if (rsp_valid && rsp_ready) begin
        got = 1; r_res = rsp_result; r_tag = rsp_tag; r_err = rsp_err;
      end
      #2;
      if (got) begin
        rsp_ready = 1'b0; req_valid = 1'b0;
      end else begin
        if (rsp_valid) cnt++;
        rsp_ready = rsp_valid ? (cnt > bp) : 1'($urandom_range(0, 1));
        if (noise) begin
          req_valid = 1'($urandom_range(0, 1));
          req_op = Operation'($urandom_range(0, 2));
          req_a = $urandom; req_b = $urandom; req_tag = 5'($urandom_range(0, 31));
        end
      end
    end
    if (!got) chk("response_bound", 32'(got), 32'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  logic [31:0] r_res;
  logic [4:0]  r_tag;
  logic [1:0]  r_err;
  int          aw;
  bit          got_rst;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = ADD; req_a = 32'd0; req_b = 32'd0;
    req_tag = 5'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2;

    do_req(ADD, 32'h40400000, 32'h40000000, 5'd7, 5, 0, 1'b0, r_res, r_tag, r_err, aw);
    chk("add_result", r_res, 32'h40A00000);
    chk("add_tag", r_tag, 32'd7);
    chk("add_err", r_err, 32'd0);
    chk("add_latency", last_latency, 32'd5);

    do_req(SUB, 32'hC1400000, 32'h41200000, 5'd3, 8, 10, 1'b1, r_res, r_tag, r_err, aw);
    chk("sub_result", r_res, 32'hC1B00000);
    chk("sub_err", r_err, 32'd0);

    do_req(MUL, 32'h41200000, 32'hC1400000, 5'd12, 3, 0, 1'b0, r_res, r_tag, r_err, aw);
    chk("mul_result", r_res, 32'hC2F00000);
    chk("mul_b2b_accept", aw, 32'd1);
    do_req(MUL, 32'h41200000, 32'hC1400000, 5'd13, 1, 0, 1'b0, r_res, r_tag, r_err, aw);
    chk("mul2_b2b_accept", aw, 32'd1);
    chk("mul2_tag", r_tag, 32'd13);

    do_req(ADD, 32'h3F800000, 32'h3F800000, 5'd9, 0, 2, 1'b0, r_res, r_tag, r_err, aw);
    chk("nobusy_err", r_err, 32'd1);
    chk("nobusy_result", r_res, 32'h7FC00000);
    chk("nobusy_tag", r_tag, 32'd9);

    do_req(SUB, 32'h12345678, 32'h0BADF00D, 5'd1, TO - 1, 0, 1'b0, r_res, r_tag, r_err, aw);
    chk("edge_ok_err", r_err, 32'd0);
    chk("edge_ok_latency", last_latency, 32'(TO - 1));
    do_req(ADD, 32'h11111111, 32'h22222222, 5'd2, TO, 1, 1'b0, r_res, r_tag, r_err, aw);
    chk("edge_to_err", r_err, 32'd2);
    chk("edge_to_result", r_res, 32'h7FC00000);
    chk("latency_held", last_latency, 32'(TO - 1));

    do_req(MUL, 32'h40000000, 32'h40000000, 5'd21, 200, 0, 1'b1, r_res, r_tag, r_err, aw);
    chk("timeout_err", r_err, 32'd2);
    chk("timeout_tag", r_tag, 32'd21);

    // Abandon an operation mid-flight with an asynchronous reset.
    cur_lat = 30; req_op = MUL; req_a = 32'h3F000000; req_b = 32'h40800000; req_tag = 5'd5;
    req_valid = 1'b1; got_rst = 0;
    for (int n = 0; n < 400 && !got_rst; n++) begin
      @(posedge clk);
      if (req_ready) got_rst = 1;
    end
    #2 req_valid = 1'b0;
    chk("rst_seq_accept", 32'(got_rst), 32'd1);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_ctrl", {27'd0, req_ready, fpu_start, rsp_valid, fpu_op}, 32'd0);
    chk("rst_err", rsp_err, 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_b", fpu_b, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_tag", rsp_tag, 32'd0);
    chk("rst_latency", last_latency, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    do_req(ADD, 32'h40400000, 32'h40000000, 5'd7, 4, 1, 1'b0, r_res, r_tag, r_err, aw);
    chk("post_rst_result", r_res, 32'h40A00000);
    chk("post_rst_tag", r_tag, 32'd7);
    chk("post_rst_latency", last_latency, 32'd4);

    for (int i = 0; i < 40; i++) begin
      int sel, lat;
      sel = $urandom_range(0, 9);
      if (sel == 0) lat = 0;
      else if (sel == 1) lat = $urandom_range(TO - 4, TO + 6);
      else lat = $urandom_range(1, 12);
      do_req(Operation'($urandom_range(0, 2)), $urandom, $urandom, 5'($urandom_range(0, 31)),
             lat, $urandom_range(0, 4), 1'($urandom_range(0, 1)), r_res, r_tag, r_err, aw);
    end
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
